// File: rtl/accel_spi_pkg.sv
// Shared constants and state encoding for the accelerometer SPI responder.
package accel_spi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [3:0] ADDR_DEVID = 4'h0;
    localparam logic [3:0] ADDR_XDATA = 4'h8;
    localparam logic [3:0] ADDR_YDATA = 4'h9;
    localparam logic [3:0] ADDR_ZDATA = 4'hA;

    // One bit per address; set bits are read-only (DEVID and the sample shadows).
    localparam logic [15:0] RO_MASK = 16'h0701;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    function automatic logic addr_is_ro(input logic [3:0] addr);
        return RO_MASK[addr];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall pulses taken from
// the synchronized level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 slave emulating the accelerometer register file (0x0B read, 0x0A write).
// Define ACCEL_RESP_AUTOINC_EN to auto-increment the address after every data byte.
module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter logic [7:0]  DEVID       = 8'hAD,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] x_data,
    input  logic [7:0] y_data,
    input  logic [7:0] z_data,
    output logic       reg_wr,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       busy
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_unused_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .din(CS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(SCLK),
        .level(sclk_unused_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(MOSI),
        .level(mosi_lvl), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
    );

    state_t     state, state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in, shift_out, byte_in, rdata, load_val;
    logic [3:0] addr;
    logic       is_read;
    logic       write_ok;
    logic [7:0] shadow_x, shadow_y, shadow_z;
    logic [7:0] regfile [16];
`ifndef ACCEL_RESP_AUTOINC_EN
    logic       data_done;
`endif

    assign byte_in = {shift_in[6:0], mosi_lvl};
    assign MISO    = shift_out[7];
    assign busy    = ~cs_lvl;

    always_comb begin
        unique case (addr)
            ADDR_DEVID: rdata = DEVID;
            ADDR_XDATA: rdata = shadow_x;
            ADDR_YDATA: rdata = shadow_y;
            ADDR_ZDATA: rdata = shadow_z;
            default:    rdata = regfile[addr];
        endcase
    end

`ifdef ACCEL_RESP_AUTOINC_EN
    assign load_val = rdata;
    assign write_ok = ~addr_is_ro(addr);
`else
    assign load_val = data_done ? '0 : rdata;
    assign write_ok = ~addr_is_ro(addr) & ~data_done;
`endif

    // CS rise is checked first so a coincident SCLK edge is ignored.
    always_comb begin
        state_next = state;
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall) state_next = ST_CMD;
                ST_CMD: begin
                    if (sclk_rise && bit_cnt == 3'd7)
                        state_next = (byte_in == CMD_WRITE || byte_in == CMD_READ) ? ST_ADDR : ST_IGNORE;
                end
                ST_ADDR: if (sclk_rise && bit_cnt == 3'd7) state_next = ST_DATA;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            shadow_x  <= '0;
            shadow_y  <= '0;
            shadow_z  <= '0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
`ifndef ACCEL_RESP_AUTOINC_EN
            data_done <= 1'b0;
`endif
            for (int unsigned i = 0; i < 16; i++) regfile[i] <= '0;
        end else begin
            state  <= state_next;
            reg_wr <= 1'b0;
            if (cs_fall) begin
                shadow_x  <= x_data;
                shadow_y  <= y_data;
                shadow_z  <= z_data;
                bit_cnt   <= '0;
                shift_in  <= '0;
                shift_out <= '0;
                addr      <= '0;
`ifndef ACCEL_RESP_AUTOINC_EN
                data_done <= 1'b0;
`endif
            end else if (cs_rise) begin
                shift_out <= '0;
            end else if (state == ST_CMD || state == ST_ADDR || state == ST_DATA) begin
                if (sclk_rise) begin
                    shift_in <= byte_in;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == ST_CMD)  is_read <= (byte_in == CMD_READ);
                        if (state == ST_ADDR) addr    <= byte_in[3:0];
                        if (state == ST_DATA) begin
                            if (!is_read && write_ok) begin
                                regfile[addr] <= byte_in;
                                reg_wr        <= 1'b1;
                                reg_addr      <= addr;
                                reg_wdata     <= byte_in;
                            end
`ifdef ACCEL_RESP_AUTOINC_EN
                            addr <= addr + 4'd1;
`else
                            data_done <= 1'b1;
`endif
                        end
                    end
                end
                // A fall with bit_cnt==0 closes a byte: reload, else shift.
                if (sclk_fall && state == ST_DATA && is_read)
                    shift_out <= (bit_cnt == 3'd0) ? load_val : {shift_out[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Scoreboard bench for accel_spi_responder: expected MISO bytes and register
// writes are queued as stimulus is built, then compared against DUT output.
module tb_accel_spi_responder;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset, CS, SCLK, MOSI, MISO;
    logic [7:0] x_data, y_data, z_data;
    logic       reg_wr, busy;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  model_regs [16];
    logic [7:0]  tx_q[$], rx_q[$], exp_rd[$];
    logic [11:0] exp_wr[$], obs_wr[$];

    always #5 clk = ~clk;

    accel_spi_responder #(.DEVID(8'hAD), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .x_data(x_data), .y_data(y_data), .z_data(z_data),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .busy(busy)
    );

    always @(negedge clk) if (reg_wr === 1'b1) obs_wr.push_back({reg_addr, reg_wdata});

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic is_ro(input logic [3:0] a);
        return (a == 4'h0) || (a >= 4'h8 && a <= 4'hA);
    endfunction

    function automatic logic [7:0] model_rd(input logic [3:0] a);
        case (a)
            4'h0:    return 8'hAD;
            4'h8:    return x_data;
            4'h9:    return y_data;
            4'hA:    return z_data;
            default: return model_regs[a];
        endcase
    endfunction

    // Mode 0: master sets MOSI while SCLK low, samples MISO just before the rise.
    task automatic run_txn(input int last_bits);
        logic [7:0] b, r;
        rx_q.delete();
        CS = 1'b0;
        wait_clk(H);
        for (int k = 0; k < tx_q.size(); k++) begin
            int nb;
            nb = (k == tx_q.size() - 1) ? last_bits : 8;
            b  = tx_q[k];
            r  = '0;
            for (int i = 7; i >= 8 - nb; i--) begin
                MOSI = b[i];
                wait_clk(H);
                r[i] = MISO;
                SCLK = 1'b1;
                wait_clk(H);
                SCLK = 1'b0;
            end
            rx_q.push_back(r);
        end
        wait_clk(H);
        CS   = 1'b1;
        MOSI = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic prep_write(input logic [3:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
        logic [3:0] wa;
        logic [7:0] d;
        logic       act;
        tx_q.delete();
        tx_q.push_back(8'h0A);
        tx_q.push_back({4'h3, a});
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h00);
        for (int j = 0; j < n; j++) begin
            d = (j == 0) ? d0 : d1;
            tx_q.push_back(d);
            exp_rd.push_back(8'h00);
`ifdef ACCEL_RESP_AUTOINC_EN
            wa  = a + 4'(j);
            act = 1'b1;
`else
            wa  = a;
            act = (j == 0);
`endif
            if (act && !is_ro(wa)) begin
                model_regs[wa] = d;
                exp_wr.push_back({wa, d});
            end
        end
    endtask

    task automatic prep_read(input logic [3:0] a, input int n);
        tx_q.delete();
        tx_q.push_back(8'h0B);
        tx_q.push_back({4'hC, a});
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h00);
        for (int j = 0; j < n; j++) begin
            tx_q.push_back(8'h00);
`ifdef ACCEL_RESP_AUTOINC_EN
            exp_rd.push_back(model_rd(a + 4'(j)));
`else
            exp_rd.push_back((j == 0) ? model_rd(a) : 8'h00);
`endif
        end
    endtask

    task automatic test_reset;
        logic [7:0] e, o;
        reset = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        x_data = 8'h00; y_data = 8'h00; z_data = 8'h00;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        wait_clk(5);
        n_cmp++; if (MISO !== 1'b0)      begin n_err++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        n_cmp++; if (reg_wr !== 1'b0)    begin n_err++; $display("FAIL reset_reg_wr: got %b expected 0", reg_wr); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (reg_addr !== 4'h0)  begin n_err++; $display("FAIL reset_reg_addr: got %h expected 0", reg_addr); end
        n_cmp++; if (reg_wdata !== 8'h0) begin n_err++; $display("FAIL reset_reg_wdata: got %h expected 00", reg_wdata); end
        reset = 1'b1;
        wait_clk(5);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
        CS = 1'b0;
        wait_clk(5);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL cs_low_busy: got %b expected 1", busy); end
        CS = 1'b1;
        wait_clk(5);
        prep_read(4'h0, 1);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL read_devid byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_write_read;
        logic [7:0]  e, o;
        logic [11:0] we, wo;
        prep_write(4'h3, 1, 8'h5C, 8'h00);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL write3 miso byte: got %h expected %h", o, e); end
        end
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL write3 reg_wr count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            we = exp_wr.pop_front(); wo = obs_wr.pop_front();
            n_cmp++; if (wo !== we) begin n_err++; $display("FAIL write3 addr/data: got %h expected %h", wo, we); end
        end
        exp_wr.delete(); obs_wr.delete();
        prep_read(4'h3, 1);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL read3 byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_ro_shadow;
        logic [7:0] e, o;
        prep_write(4'h8, 1, 8'hFF, 8'h00);
        run_txn(8);
        exp_rd.delete();
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL ro_write reg_wr count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
        exp_wr.delete(); obs_wr.delete();
        x_data = 8'h63; y_data = 8'h71; z_data = 8'h82;
        prep_read(4'h8, 1);
        fork
            run_txn(8);
            begin wait_clk(60); x_data = 8'h9E; end
        join
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL shadow_x byte: got %h expected %h", o, e); end
        end
        prep_read(4'hA, 1);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL shadow_z byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_partial;
        logic [7:0] e, o;
        tx_q.delete();
        tx_q.push_back(8'h0A); tx_q.push_back(8'h05); tx_q.push_back(8'hA5);
        run_txn(5);
        n_cmp++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL partial reg_wr count: got %0d expected 0", obs_wr.size()); end
        obs_wr.delete();
        prep_read(4'h5, 1);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL partial read5 byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_burst;
        logic [7:0]  e, o;
        logic [11:0] we, wo;
        prep_write(4'hF, 1, 8'h3C, 8'h00);
        run_txn(8);
        exp_rd.delete();
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL writeF reg_wr count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            we = exp_wr.pop_front(); wo = obs_wr.pop_front();
            n_cmp++; if (wo !== we) begin n_err++; $display("FAIL writeF addr/data: got %h expected %h", wo, we); end
        end
        exp_wr.delete(); obs_wr.delete();
        prep_read(4'hF, 2);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL burst_readF byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  e, o;
        logic [11:0] we, wo;
        prep_write(4'h7, 2, 8'h11, 8'h22);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL burst_write7 miso byte: got %h expected %h", o, e); end
        end
        n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL burst_write7 reg_wr count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            we = exp_wr.pop_front(); wo = obs_wr.pop_front();
            n_cmp++; if (wo !== we) begin n_err++; $display("FAIL burst_write7 addr/data: got %h expected %h", wo, we); end
        end
        exp_wr.delete(); obs_wr.delete();
        prep_read(4'h7, 2);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL burst_read7 byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_bad_cmd;
        logic [7:0] e, o;
        tx_q.delete();
        tx_q.push_back(8'h55); tx_q.push_back(8'h03); tx_q.push_back(8'hFF);
        run_txn(8);
        for (int k = 0; k < 3; k++) begin
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== 8'h00) begin n_err++; $display("FAIL bad_cmd miso byte %0d: got %h expected 00", k, o); end
        end
        n_cmp++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL bad_cmd reg_wr count: got %0d expected 0", obs_wr.size()); end
        obs_wr.delete();
        prep_read(4'h3, 1);
        run_txn(8);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL after_bad_cmd read3 byte: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_ro_shadow();
        test_partial();
        test_burst();
        test_back_to_back();
        test_bad_cmd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
